// File: rtl/inst_encoder_pkg.sv
// Shared opcode/funct3 constants, immediate limits and the request field bundle
// used by the RV32I instruction encoder.
package inst_encoder_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_OP     = 7'b0110011;

  localparam logic [FUNCT3_W-1:0] FUNCT3_SLL = 3'b001;
  localparam logic [FUNCT3_W-1:0] FUNCT3_SR  = 3'b101;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [INST_W-1:0]   imm;
  } inst_fields_t;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request / memory-write bundle between the loader and the instruction encoder.
interface inst_encoder_if
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);
  logic                  Req_Valid_i;
  logic                  Req_Ready_o;
  logic [OPCODE_W-1:0]   Opcode_i;
  logic [REG_W-1:0]      Rd_i;
  logic [REG_W-1:0]      Rs1_i;
  logic [REG_W-1:0]      Rs2_i;
  logic [FUNCT3_W-1:0]   Funct3_i;
  logic [FUNCT7_W-1:0]   Funct7_i;
  logic [INST_W-1:0]     Imm_i;
  logic                  Addr_Load_i;
  logic [ADDR_W-1:0]     Addr_i;
  logic                  Wr_Valid_o;
  logic                  Wr_Ready_i;
  logic [ADDR_W-1:0]     Wr_Addr_o;
  logic [INST_W-1:0]     Wr_Data_o;
  logic                  Err_o;
  logic [ERR_CNT_W-1:0]  Err_Cnt_o;

  modport master (
    output Req_Valid_i, Opcode_i, Rd_i, Rs1_i, Rs2_i, Funct3_i, Funct7_i, Imm_i,
           Addr_Load_i, Addr_i, Wr_Ready_i,
    input  Req_Ready_o, Wr_Valid_o, Wr_Addr_o, Wr_Data_o, Err_o, Err_Cnt_o
  );

  modport slave (
    input  Req_Valid_i, Opcode_i, Rd_i, Rs1_i, Rs2_i, Funct3_i, Funct7_i, Imm_i,
           Addr_Load_i, Addr_i, Wr_Ready_i,
    output Req_Ready_o, Wr_Valid_o, Wr_Addr_o, Wr_Data_o, Err_o, Err_Cnt_o
  );
endinterface

// File: rtl/inst_field_chk.sv
// Combinational legality check of an opcode and its immediate against the
// range the target instruction format can represent.
module inst_field_chk
  import inst_encoder_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [INST_W-1:0]   imm,
  output logic                legal
);
  int imm_s;
  assign imm_s = $signed(imm);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPCODE_OP_IMM: begin
        if (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SR)
          legal = in_range(imm_s, SHAMT_MIN, SHAMT_MAX);
        else
          legal = in_range(imm_s, IMM12_MIN, IMM12_MAX);
      end
      OPCODE_LOAD, OPCODE_STORE: legal = in_range(imm_s, IMM12_MIN, IMM12_MAX);
      // Branch offsets are halfword-aligned, so bit 0 is never encoded.
      OPCODE_BRANCH: legal = in_range(imm_s, IMM_B_MIN, IMM_B_MAX) && !imm[0];
      OPCODE_OP:     legal = 1'b1;
      default:       legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into machine words and streams them into
// instruction memory at an auto-incrementing word pointer.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  inst_encoder_if.slave bus
);
  inst_fields_t      req;
  logic              legal_c;
  logic              accept_c;
  logic [INST_W-1:0] word_c;
  logic [ADDR_W-1:0] ptr;
  logic              unused_imm_hi;

  assign req = '{opcode: bus.Opcode_i, rd: bus.Rd_i, rs1: bus.Rs1_i, rs2: bus.Rs2_i,
                 funct3: bus.Funct3_i, funct7: bus.Funct7_i, imm: bus.Imm_i};
  assign unused_imm_hi = ^req.imm[INST_W-1:13];

  inst_field_chk u_chk (
    .opcode (req.opcode),
    .funct3 (req.funct3),
    .imm    (req.imm),
    .legal  (legal_c)
  );

  // The output slot is free when empty or draining this cycle.
  assign bus.Req_Ready_o = !rst_i && !bus.Addr_Load_i && (!bus.Wr_Valid_o || bus.Wr_Ready_i);
  assign accept_c        = bus.Req_Valid_i && bus.Req_Ready_o;

  always_comb begin
    word_c = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
    case (req.opcode)
      OPCODE_OP_IMM: begin
        if (req.funct3 == FUNCT3_SLL || req.funct3 == FUNCT3_SR)
          word_c = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
        else
          word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      OPCODE_LOAD:
        word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      OPCODE_STORE:
        word_c = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      OPCODE_BRANCH:
        word_c = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                  req.imm[4:1], req.imm[11], req.opcode};
      default: ;
    endcase
  end

  // Output slot, error reporting and write pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.Wr_Valid_o <= 1'b0;
      bus.Wr_Addr_o  <= '0;
      bus.Wr_Data_o  <= '0;
      bus.Err_o      <= 1'b0;
      bus.Err_Cnt_o  <= '0;
      ptr            <= ADDR_W'(BASE_ADDR);
    end else begin
      bus.Err_o <= accept_c && !legal_c;
      if (accept_c && !legal_c && bus.Err_Cnt_o != {ERR_CNT_W{1'b1}})
        bus.Err_Cnt_o <= bus.Err_Cnt_o + ERR_CNT_W'(1);
      if (bus.Wr_Ready_i)
        bus.Wr_Valid_o <= 1'b0;
      if (accept_c && legal_c) begin
        bus.Wr_Valid_o <= 1'b1;
        bus.Wr_Addr_o  <= ptr;
        bus.Wr_Data_o  <= word_c;
        ptr            <= ptr + ADDR_W'(1);
      end
      // Never coincides with an accept, since ready is held low during a load.
      if (bus.Addr_Load_i)
        ptr <= bus.Addr_i;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed and random requests checked
// against a field-level reference model of the encoder.
module tb_inst_encoder;
  localparam int unsigned ADDR_W = 10;
  localparam int BASE = 0;
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct {
    int due;
    bit valid;
    bit err;
    int cnt;
    bit zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t        sq[$];
  logic [41:0] wq[$];
  exp_t        mon_e;

  int m_ptr = BASE;
  bit m_pend = 1'b0;
  int m_cnt = 0;

  inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference encoder written from the instruction-format rules.
  function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm, output bit ok, output logic [31:0] w);
    int s;
    s  = $signed(imm);
    ok = 1'b0;
    w  = 32'h0;
    case (op)
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ok = (s >= 0) && (s <= 31);
          w  = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = {imm[11:0], rs1, f3, rd, op};
        end
      end
      7'b0000011: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {imm[11:0], rs1, f3, rd, op};
      end
      7'b0100011: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      7'b1100011: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      7'b0110011: begin
        ok = 1'b1;
        w  = {f7, rs2, rs1, f3, rd, op};
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // One clock of stimulus; the model predicts ready and queues expectations.
  task automatic drive(input bit r, input bit v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input bit ld,
                       input logic [9:0] la, input bit wr, input logic [31:0] known);
    bit          rdy, ok, acc;
    logic [31:0] w;
    exp_t        e;
    @(posedge clk);
    #2;
    rst = r;
    bus.Req_Valid_i = v;  bus.Opcode_i = op;  bus.Rd_i = rd;  bus.Rs1_i = rs1;
    bus.Rs2_i = rs2;      bus.Funct3_i = f3;  bus.Funct7_i = f7;  bus.Imm_i = imm;
    bus.Addr_Load_i = ld; bus.Addr_i = la;    bus.Wr_Ready_i = wr;
    rdy = !r && !ld && (!m_pend || wr);
    #1;
    chk("req_ready", 64'(bus.Req_Ready_o), 64'(rdy));
    ref_enc(op, rd, rs1, rs2, f3, f7, imm, ok, w);
    if (known != 32'h0) w = known;
    acc = v && rdy;
    e.zero = 1'b0;
    e.err  = 1'b0;
    if (r) begin
      m_pend = 1'b0;
      m_cnt  = 0;
      m_ptr  = BASE;
      wq.delete();
      e.zero = 1'b1;
    end else begin
      m_pend = (m_pend && !wr) || (acc && ok);
      if (acc && ok) begin
        wq.push_back({10'(m_ptr), w});
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (acc && !ok) begin
        e.err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      if (ld) m_ptr = int'(la);
    end
    e.due   = cyc + 1;
    e.valid = m_pend;
    e.cnt   = m_cnt;
    sq.push_back(e);
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input bit wr, input logic [31:0] known);
    drive(1'b0, 1'b1, op, rd, rs1, rs2, f3, f7, imm, 1'b0, 10'h0, wr, known);
  endtask

  task automatic idle(input bit wr);
    drive(1'b0, 1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0, 10'h0, wr, 32'h0);
  endtask

  task automatic rst_cyc(input bit wr);
    drive(1'b1, 1'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 1'b0, 10'h0, wr, 32'h0);
  endtask

  // Monitor: per-cycle status expectations plus the write-word scoreboard.
  always @(negedge clk) begin
    if (sq.size() > 0 && sq[0].due == cyc) begin
      mon_e = sq.pop_front();
      chk("wr_valid", 64'(bus.Wr_Valid_o), 64'(mon_e.valid));
      chk("err_pulse", 64'(bus.Err_o), 64'(mon_e.err));
      chk("err_cnt", 64'(bus.Err_Cnt_o), 64'(mon_e.cnt));
      if (mon_e.zero) begin
        chk("rst_addr", 64'(bus.Wr_Addr_o), 64'h0);
        chk("rst_data", 64'(bus.Wr_Data_o), 64'h0);
      end
    end
    if (!rst && bus.Wr_Valid_o === 1'b1) begin
      if (wq.size() == 0) begin
        chk("wr_unexpected", 64'h1, 64'h0);
      end else begin
        chk("wr_word", 64'({bus.Wr_Addr_o, bus.Wr_Data_o}), 64'(wq[0]));
        if (bus.Wr_Ready_i) void'(wq.pop_front());
      end
    end
  end

  logic [6:0] ops[6] = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b1110011};
  int         edges[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098, 31, 32, -1, 0};

  initial begin
    bus.Req_Valid_i = 1'b0;  bus.Opcode_i = '0;  bus.Rd_i = '0;  bus.Rs1_i = '0;
    bus.Rs2_i = '0;          bus.Funct3_i = '0;  bus.Funct7_i = '0;  bus.Imm_i = '0;
    bus.Addr_Load_i = 1'b0;  bus.Addr_i = '0;    bus.Wr_Ready_i = 1'b0;

    rst_cyc(1'b1);
    rst_cyc(1'b1);

    // addi x1,x2,-1; then sw / beq back-to-back
    req(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'h0, 32'hFFFF_FFFF, 1'b1, 32'hFFF1_0093);
    idle(1'b1);
    req(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'h0, 32'd8, 1'b1, 32'h0051_2423);
    req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h0, -32'sd4, 1'b1, 32'hFE20_8EE3);
    idle(1'b1);

    // illegal branch offset, out-of-range addi, then a legal word at the same address
    req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h0, 32'd3, 1'b1, 32'h0);
    req(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b000, 7'h0, 32'd2048, 1'b1, 32'h0);
    req(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b000, 7'h0, 32'd5, 1'b1, 32'h0);
    idle(1'b1);

    // backpressure: three stalled cycles, second request re-offered until taken
    rst_cyc(1'b1);
    req(7'b0110011, 5'd7, 5'd8, 5'd9, 3'b000, 7'h20, 32'h0, 1'b0, 32'h0);
    req(7'b0000011, 5'd6, 5'd1, 5'd0, 3'b010, 7'h0, 32'd100, 1'b0, 32'h0);
    req(7'b0000011, 5'd6, 5'd1, 5'd0, 3'b010, 7'h0, 32'd100, 1'b0, 32'h0);
    req(7'b0000011, 5'd6, 5'd1, 5'd0, 3'b010, 7'h0, 32'd100, 1'b1, 32'h0);
    idle(1'b1);

    // pointer load to the top address, then wrap
    drive(1'b0, 1'b1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'h0, 32'd1, 1'b1, 10'h3FF, 1'b1, 32'h0);
    req(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'h0, 32'd31, 1'b1, 32'h0);
    req(7'b0010011, 5'd2, 5'd2, 5'd0, 3'b101, 7'h20, 32'd7, 1'b1, 32'h0);
    idle(1'b1);

    // error counter saturation
    for (int i = 0; i < 300; i++)
      req(7'b1111111, 5'd0, 5'd0, 5'd0, 3'b000, 7'h0, 32'h0, 1'b1, 32'h0);
    idle(1'b1);

    // reset while a word is stalled
    req(7'b0110011, 5'd1, 5'd2, 5'd3, 3'b111, 7'h0, 32'h0, 1'b0, 32'h0);
    rst_cyc(1'b0);
    req(7'b0110011, 5'd4, 5'd5, 5'd6, 3'b110, 7'h0, 32'h0, 1'b1, 32'h0);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      case ($urandom % 3)
        0:       imm = 32'($urandom_range(0, 63)) - 32'd32;
        1:       imm = 32'(edges[$urandom % 12]);
        default: imm = $urandom;
      endcase
      drive(($urandom % 100) == 0, ($urandom % 4) != 0, ops[$urandom % 6],
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm,
            ($urandom % 20) == 0, 10'($urandom), ($urandom % 4) != 0, 32'h0);
    end

    repeat (4) idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("wq_drained", 64'(wq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Packs decoded instruction fields (opcode, registers, funct, 32-bit immediate) back into 32-bit RV32I machine words. Writes them sequentially into instruction memory through a valid/ready write port.
- Is the inverse of the decode-stage immediate path. Used by the boot/test loader to build programs in-system.
- Checks immediate legality, reports errors, and holds one encoded word under backpressure.

Parameters:
- ADDR_W, 10, word-address width of instruction memory.
- BASE_ADDR, 0, word address loaded into the write pointer at reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- Req_Valid_i  in  1  request valid
- Req_Ready_o  out  1  request accepted when Req_Valid_i && Req_Ready_o
- Opcode_i  in  7  instruction opcode
- Rd_i  in  5  rd field
- Rs1_i  in  5  rs1 field
- Rs2_i  in  5  rs2 field
- Funct3_i  in  3  funct3 field
- Funct7_i  in  7  funct7 field (OP; OP_IMM shifts)
- Imm_i  in  32  signed byte-offset immediate
- Addr_Load_i  in  1  load write pointer from Addr_i
- Addr_i  in  ADDR_W  new write pointer value
- Wr_Valid_o  out  1  encoded word pending
- Wr_Ready_i  in  1  memory accepts word
- Wr_Addr_o  out  ADDR_W  word address of pending word
- Wr_Data_o  out  32  encoded instruction
- Err_o  out  1  one-cycle pulse for a rejected request
- Err_Cnt_o  out  8  saturating rejected-request count

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - Wr_Valid_o=0, Wr_Addr_o=0, Wr_Data_o=0, Err_o=0, Err_Cnt_o=0.
  - Write pointer = BASE_ADDR.
  - Reset mid-operation drops any pending word.
- Ready: Req_Ready_o = !rst_i && !Addr_Load_i && (!Wr_Valid_o || Wr_Ready_i). It is combinational, so a full throughput of 1 word/cycle is possible.
- Latency: a request accepted in cycle N gives Wr_Valid_o/Wr_Addr_o/Wr_Data_o in cycle N+1. These outputs are held stable while Wr_Valid_o && !Wr_Ready_i.
- Legal accept:
  - Word is encoded and Wr_Addr_o = pointer.
  - Pointer increments by 1 and wraps 2^ADDR_W-1 to 0.
- Encodings:
  - OP_IMM/LOAD (I): {Imm_i[11:0], Rs1, F3, Rd, Op}.
  - OP_IMM shift (F3=001/101): {Funct7_i, Imm_i[4:0], Rs1, F3, Rd, Op}.
  - STORE (S): {Imm_i[11:5], Rs2, Rs1, F3, Imm_i[4:0], Op}.
  - BRANCH (B): {Imm_i[12], Imm_i[10:5], Rs2, Rs1, F3, Imm_i[4:1], Imm_i[11], Op}.
  - OP (R): {Funct7_i, Rs2, Rs1, F3, Rd, Op}. Imm_i is ignored.
- Legality:
  - I/S: Imm_i in -2048..2047.
  - Shift: Imm_i in 0..31.
  - B: Imm_i in -4096..4094 and Imm_i[0]=0.
  - Any other opcode is illegal.
- Illegal accept:
  - Request is consumed but not written.
  - Err_o=1 in cycle N+1; Err_Cnt_o increments, saturating at 255.
  - Pointer is unchanged.
  - Wr_Valid_o becomes 0 if the previous word completed in cycle N.
- Addr_Load_i:
  - Pointer <= Addr_i at the end of the cycle. Req_Ready_o is low that cycle, so no accept conflicts.
  - A pending word keeps its already-captured address.
- Wr_Ready_i while Wr_Valid_o=0 has no effect.

Decomposition:
- Const.v (shared):
  - Existing `OPCODE_OP_IMM/LOAD/STORE/BRANCH`.
  - Add `OPCODE_OP` (7'b0110011) and `FUNCT3_SLL`/`FUNCT3_SR` (3'b001/3'b101).
  - Add immediate range limits.
- One combinational sub-module, inst_field_chk: opcode/imm legality → legal flag.
- Packing and the output register stay in inst_encoder.

Test Plan:
- addi x1,x2,-1 (Op 0010011, Rd 1, Rs1 2, F3 0, Imm 0xFFFFFFFF), Wr_Ready_i=1 → next cycle Wr_Valid_o=1, Wr_Addr_o=0, Wr_Data_o=0xFFF10093.
- sw x5,8(x2) (Op 0100011, Rs2 5, Rs1 2, F3 010, Imm 8), then beq x1,x2,-4 (Op 1100011, Imm -4) back-to-back → 0x00512423 @0, then 0xFE208EE3 @1 on consecutive cycles.
- Errors:
  - BRANCH Imm 3 → Err_o pulse, no write, Err_Cnt_o=1.
  - OP_IMM F3 0 Imm 2048 → Err_Cnt_o=2.
  - Next legal request written at the unchanged address.
  - 300 illegal requests → Err_Cnt_o saturates at 255.
- Backpressure:
  - Wr_Ready_i=0 for 3 cycles with 2 requests offered → Req_Ready_o=0 while full, first word stable.
  - After release, words appear at addresses 0,1 in order with no loss or duplication.
- Addr_Load_i=1, Addr_i=0x3FF, then two legal requests → Wr_Addr_o 0x3FF then 0x000. Req_Ready_o=0 in the load cycle.
- rst_i asserted while Wr_Valid_o=1 and Wr_Ready_i=0 → next cycle Wr_Valid_o=0, Err_Cnt_o=0, next write at BASE_ADDR.
